// File: rtl/fifo_wr_arbiter_pkg.sv
// Package: fifo_arb_pkg
// Shared types and default constants for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM state (idle / burst in progress)
//   owner_t     : burst-owner index for the default requester count
//   Def*        : default parameter values used by the interface and top
//   wrap_inc    : modulo-n increment used for the round-robin pointer
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } arb_state_e;

    localparam int unsigned DefNumReq    = 4;
    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefMaxBurst  = 4;
    localparam int unsigned DefCntW      = 16;
    localparam int unsigned DefOwnerW    = $clog2(DefNumReq);

    typedef logic [DefOwnerW-1:0] owner_t;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Interface: fifo_wr_arbiter_if
// Bundles the producer request bus and the FIFO write-side signals.
//   req       : per-requester beat valid, held until granted
//   req_data  : per-requester data, slice i = [i*Data_Width +: Data_Width]
//   req_last  : beat is the last of the requester's packet
//   full      : FIFO full, write-clock domain
//   gnt       : one-hot beat acceptance
//   wr_en     : FIFO write enable
//   data_in   : FIFO write data
// Modports: master = producers/FIFO side, slave = arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DefNumReq,
    parameter int unsigned Data_Width = DefDataWidth
);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*Data_Width-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic                          full;
    logic [NUM_REQ-1:0]            gnt;
    logic                          wr_en;
    logic [Data_Width-1:0]         data_in;

    modport master (
        output req, req_data, req_last, full,
        input  gnt, wr_en, data_in
    );

    modport slave (
        input  req, req_data, req_last, full,
        output gnt, wr_en, data_in
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Module: rr_pick
// Combinational round-robin picker: returns the first set request at or after
// ptr, wrapping from NUM_REQ-1 back to 0.
//   req   : request vector
//   ptr   : highest-priority index
//   idx   : selected index (0 when nothing is requested)
//   valid : at least one request set
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic [IdxW-1:0] cand;

    // Scan from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IdxW'((32'(ptr) + 32'(k)) % NUM_REQ);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Module: fifo_wr_arbiter
// Shares the async FIFO write port among NUM_REQ producers in the write-clock
// domain. Round-robin arbitration with bursts of up to MAX_BURST beats per
// grant; never writes while the FIFO is full.
// Ports:
//   wr_clk    : write-domain clock
//   wr_rst    : asynchronous active-high reset
//   bus       : fifo_wr_arbiter_if.slave (req/req_data/req_last/full in,
//               gnt/wr_en/data_in out)
//   owner     : current burst owner
//   busy      : a burst is in progress
//   grant_cnt : bursts granted per requester, saturating, slice i =
//               [i*CNT_W +: CNT_W]; present only with FIFO_ARB_STATS_EN
// Build option: define FIFO_ARB_STATS_EN to add the grant counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DefNumReq,
    parameter int unsigned Data_Width = DefDataWidth,
    parameter int unsigned MAX_BURST  = DefMaxBurst,
    parameter int unsigned CNT_W      = DefCntW
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst,
    fifo_wr_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]   grant_cnt
`endif
);

    localparam int unsigned OwnerW = $clog2(NUM_REQ);
    localparam int unsigned BeatW  = $clog2(MAX_BURST + 1);

    arb_state_e        state_q;
    logic [OwnerW-1:0] owner_q;
    logic [OwnerW-1:0] rr_ptr_q;
    logic [BeatW-1:0]  beat_cnt_q;

    logic              in_burst;
    logic              owner_req;
    logic              owner_last;
    logic              wr_en_c;
    logic              burst_end;
    logic [OwnerW-1:0] owner_nxt;
    logic [OwnerW-1:0] pick_ptr;
    logic [OwnerW-1:0] pick_idx;
    logic              pick_valid;

    assign in_burst   = (state_q == StBurst);
    assign owner_req  = bus.req[owner_q];
    assign owner_last = bus.req_last[owner_q];
    assign owner_nxt  = OwnerW'(wrap_inc(32'(owner_q), NUM_REQ));

    // Write straight from the owner's request; full gates it with no latency.
    assign wr_en_c    = in_burst & owner_req & ~bus.full;
    assign burst_end  = wr_en_c &
                        (owner_last | (beat_cnt_q == BeatW'(MAX_BURST - 1)));

    // One picker serves both cases: from rr_ptr when idle, and from the slot
    // after the current owner when a burst ends (so the next owner is known
    // in the same cycle and no bubble is inserted).
    assign pick_ptr = in_burst ? owner_nxt : rr_ptr_q;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .req  (bus.req),
        .ptr  (pick_ptr),
        .idx  (pick_idx),
        .valid(pick_valid)
    );

    always_comb begin
        bus.wr_en          = wr_en_c;
        bus.gnt            = '0;
        bus.gnt[owner_q]   = wr_en_c;
        bus.data_in        = '0;
        if (wr_en_c) begin
            bus.data_in = bus.req_data[owner_q*Data_Width +: Data_Width];
        end
    end

    assign owner = owner_q;
    assign busy  = in_burst;

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        state_q    <= StBurst;
                        owner_q    <= pick_idx;
                        beat_cnt_q <= '0;
                    end
                end
                StBurst: begin
                    if (!owner_req) begin
                        // Owner withdrew: abandon the burst and pass priority on.
                        state_q    <= StIdle;
                        rr_ptr_q   <= owner_nxt;
                        beat_cnt_q <= '0;
                    end else if (wr_en_c) begin
                        if (burst_end) begin
                            rr_ptr_q   <= owner_nxt;
                            beat_cnt_q <= '0;
                            if (pick_valid) begin
                                owner_q <= pick_idx;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic                               load;
    logic [NUM_REQ-1:0][CNT_W-1:0]      grant_cnt_q;

    // A requester is counted each time it is loaded as burst owner.
    assign load = pick_valid & (in_burst ? burst_end : 1'b1);

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            grant_cnt_q <= '0;
        end else if (load && (grant_cnt_q[pick_idx] != {CNT_W{1'b1}})) begin
            grant_cnt_q[pick_idx] <= grant_cnt_q[pick_idx] + 1'b1;
        end
    end

    assign grant_cnt = grant_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: table of per-cycle vectors with hand-computed
// expectations, plus short hand-written sequences for latency and statistics.
module tb_fifo_wr_arbiter;

    logic       clk = 1'b0;
    logic       wr_rst;
    logic [1:0] owner;
    logic       busy;
`ifdef FIFO_ARB_STATS_EN
    logic [7:0] grant_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cur_vec = 0;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .Data_Width(8)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .Data_Width(8),
        .MAX_BURST (4),
`ifdef FIFO_ARB_STATS_EN
        .CNT_W     (2)
`else
        .CNT_W     (16)
`endif
    ) dut (
        .wr_clk   (clk),
        .wr_rst   (wr_rst),
        .bus      (bus),
        .owner    (owner),
`ifdef FIFO_ARB_STATS_EN
        .busy     (busy),
        .grant_cnt(grant_cnt)
`else
        .busy     (busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] last;
        logic       full;
        logic       wr_en;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] last,
                       input logic full, input logic wr_en, input logic [3:0] gnt,
                       input logic [1:0] own, input logic bsy);
        vec_t v;
        v.rst = rst; v.req = req; v.last = last; v.full = full;
        v.wr_en = wr_en; v.gnt = gnt; v.owner = own; v.busy = bsy;
        vecs.push_back(v);
    endtask

    // Requester i presents byte 8'(4*v + i) in vector v.
    function automatic logic [31:0] vdata(input int v);
        return {8'(4 * v + 3), 8'(4 * v + 2), 8'(4 * v + 1), 8'(4 * v)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got %0h, expected %0h", name, cur_vec, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] last,
                         input logic full, input int v);
        @(negedge clk);
        wr_rst       = rst;
        bus.req      = req;
        bus.req_last = last;
        bus.full     = full;
        bus.req_data = vdata(v);
        #1;
    endtask

    initial begin
        logic [7:0] exp_data;
        int         n;
        logic       found;

        wr_rst       = 1'b1;
        bus.req      = '0;
        bus.req_last = '0;
        bus.full     = 1'b0;
        bus.req_data = '0;

        // 1: single requester, 3-beat packet, one bubble from idle.
        add(1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0);
        add(0, 4'h1, 4'h0, 0, 0, 4'h0, 0, 0);
        add(0, 4'h1, 4'h0, 0, 1, 4'h1, 0, 1);
        add(0, 4'h1, 4'h0, 0, 1, 4'h1, 0, 1);
        add(0, 4'h1, 4'h1, 0, 1, 4'h1, 0, 1);
        add(0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 1);
        add(0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0);

        // 2: all requesting, no last: 4-beat bursts rotating 0,1,2,3,0 with no bubble.
        add(1, 4'hF, 4'h0, 0, 0, 4'h0, 0, 0);
        add(0, 4'hF, 4'h0, 0, 0, 4'h0, 0, 0);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) begin
                add(0, 4'hF, 4'h0, 0, 1, 4'(1 << b), 2'(b), 1);
            end
        end
        add(0, 4'hF, 4'h0, 0, 1, 4'h1, 0, 1);
        add(0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 1);
        add(0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0);

        // 3: full for 5 cycles after beat 2; beat count must hold so the burst
        // still ends after beat 4 and passes to requester 2.
        add(0, 4'h2, 4'h0, 0, 0, 4'h0, 0, 0);
        add(0, 4'h6, 4'h0, 0, 1, 4'h2, 1, 1);
        add(0, 4'h6, 4'h0, 0, 1, 4'h2, 1, 1);
        for (int k = 0; k < 5; k++) begin
            add(0, 4'h6, 4'h0, 1, 0, 4'h0, 1, 1);
        end
        add(0, 4'h6, 4'h0, 0, 1, 4'h2, 1, 1);
        add(0, 4'h6, 4'h0, 0, 1, 4'h2, 1, 1);
        add(0, 4'h6, 4'h0, 0, 1, 4'h4, 2, 1);
        add(0, 4'h0, 4'h0, 0, 0, 4'h0, 2, 1);
        add(0, 4'h0, 4'h0, 0, 0, 4'h0, 2, 0);

        // 4: owner 1 drops after 2 beats, requester 2 waiting: idle, bubble, owner 2.
        add(0, 4'h2, 4'h0, 0, 0, 4'h0, 2, 0);
        add(0, 4'h2, 4'h0, 0, 1, 4'h2, 1, 1);
        add(0, 4'h6, 4'h0, 0, 1, 4'h2, 1, 1);
        add(0, 4'h4, 4'h0, 0, 0, 4'h0, 1, 1);
        add(0, 4'h4, 4'h0, 0, 0, 4'h0, 1, 0);
        add(0, 4'h4, 4'h4, 0, 1, 4'h4, 2, 1);
        add(0, 4'h0, 4'h0, 0, 0, 4'h0, 2, 1);
        add(0, 4'h0, 4'h0, 0, 0, 4'h0, 2, 0);

        // 5: reset mid-burst kills the write at once; afterwards 4'hC -> owner 2.
        add(0, 4'h8, 4'h0, 0, 0, 4'h0, 2, 0);
        add(0, 4'h8, 4'h0, 0, 1, 4'h8, 3, 1);
        add(1, 4'h8, 4'h0, 0, 0, 4'h0, 0, 0);
        add(0, 4'hC, 4'h0, 0, 0, 4'h0, 0, 0);
        add(0, 4'hC, 4'h0, 0, 1, 4'h4, 2, 1);
        add(0, 4'h0, 4'h0, 0, 0, 4'h0, 2, 1);
        add(0, 4'h0, 4'h0, 0, 0, 4'h0, 2, 0);

        // 6: single-beat packets hand over without a bubble, pointer wraps 3 -> 0.
        add(0, 4'h3, 4'h1, 0, 0, 4'h0, 2, 0);
        add(0, 4'h3, 4'h1, 0, 1, 4'h1, 0, 1);
        add(0, 4'h3, 4'h2, 0, 1, 4'h2, 1, 1);
        add(0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 1);
        add(0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cur_vec = i;
            drive(vecs[i].rst, vecs[i].req, vecs[i].last, vecs[i].full, i);
            exp_data = vecs[i].wr_en ? 8'(4 * i + int'(vecs[i].owner)) : 8'h00;
            chk("wr_en", 32'(bus.wr_en), 32'(vecs[i].wr_en));
            chk("gnt", 32'(bus.gnt), 32'(vecs[i].gnt));
            chk("data_in", 32'(bus.data_in), 32'(exp_data));
            chk("owner", 32'(owner), 32'(vecs[i].owner));
            chk("busy", 32'(busy), 32'(vecs[i].busy));
            chk("no_write_when_full", 32'(bus.wr_en & bus.full), 32'(0));
        end

        // First write after a request from idle lands exactly one cycle later.
        cur_vec = -1;
        drive(1, 4'h0, 4'h0, 0, 0);
        drive(0, 4'h4, 4'h0, 0, 1);
        n     = 0;
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            if (bus.wr_en) begin
                found = 1'b1;
            end else begin
                n++;
                drive(0, 4'h4, 4'h0, 0, 1);
            end
        end
        chk("latency_seen", 32'(found), 32'(1));
        chk("latency_cycles", 32'(n), 32'(1));
        chk("latency_gnt", 32'(bus.gnt), 32'h4);
        chk("latency_data", 32'(bus.data_in), 32'h06);
        drive(0, 4'h0, 4'h0, 0, 0);
        drive(0, 4'h0, 4'h0, 0, 0);

`ifdef FIFO_ARB_STATS_EN
        // Eight 4-beat bursts: two loads per requester; then the 2-bit counters saturate.
        cur_vec = -2;
        drive(1, 4'h0, 4'h0, 0, 0);
        chk("stats_reset", 32'(grant_cnt), 32'h00);
        drive(0, 4'hF, 4'h0, 0, 0);
        for (int c = 0; c < 32; c++) begin
            drive(0, 4'hF, 4'h0, 0, 0);
        end
        chk("stats_8_bursts", 32'(grant_cnt), 32'hAA);
        for (int c = 0; c < 16; c++) begin
            drive(0, 4'hF, 4'h0, 0, 0);
        end
        chk("stats_saturate", 32'(grant_cnt), 32'hFF);
        drive(0, 4'h0, 4'h0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
